// File: rtl/tjmono_readout_pkg.sv
// Shared types and widths for the pixel-matrix readout controller.
// Hit word layout: {col_addr, col_data}, streamed MSB first.
package tjmono_readout_pkg;

  localparam int COL_ADDR_W = 6;
  localparam int COL_DATA_W = 21;
  localparam int WORD_W     = 27;
  localparam int TS_W       = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    READ,
    WAIT,
    SHIFT,
    GAP,
    HOLD
  } state_t;

  typedef struct packed {
    logic [COL_ADDR_W-1:0] col_addr;
    logic [COL_DATA_W-1:0] col_data;
  } hit_word_t;

  // Token synchroniser needs two cycles to see the post-read token.
  function automatic int gap_cycles(input int read_gap);
    return (read_gap > 2) ? read_gap : 2;
  endfunction

endpackage

// File: rtl/tjmono_rx_shift.sv
// Serial-to-parallel receiver: 27 samples after start, MSB first.
// done_o is raised during the final sample; word_o is valid with it.
module tjmono_rx_shift
  import tjmono_readout_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start_i,
  input  logic      din_i,
  output logic      done_o,
  output hit_word_t word_o
);

  logic              active_q;
  logic [4:0]        cnt_q;
  logic [WORD_W-2:0] sh_q;

  assign done_o = active_q && (cnt_q == 5'(WORD_W - 1));
  assign word_o = {sh_q, din_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      sh_q     <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
    end else if (active_q) begin
      sh_q  <= {sh_q[WORD_W-3:0], din_i};
      cnt_q <= cnt_q + 5'd1;
      if (done_o) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/tjmono_readout_ctrl.sv
// DAQ-side readout controller: Freeze/Read sequencing, word capture.
// Define TJMONO_READOUT_TIMESTAMP_EN to add the per-frame WordTs output.
module tjmono_readout_ctrl
  import tjmono_readout_pkg::*;
#(
  parameter int READ_LAT     = 2,
  parameter int FREEZE_SETUP = 4,
  parameter int FREEZE_HOLD  = 2,
  parameter int READ_GAP     = 1
) (
  input  logic              Clk,
  input  logic              RstB,
  input  logic              Enable,
  input  logic              TokenIn,
  input  logic              DataIn,
  output logic              Read,
  output logic              Freeze,
  output logic [WORD_W-1:0] WordData,
  output logic              WordValid,
  input  logic              WordReady,
  output logic              Busy,
`ifdef TJMONO_READOUT_TIMESTAMP_EN
  output logic [TS_W-1:0]   WordTs,
`endif
  output logic [15:0]       WordCount
);

  localparam int GAP_CYC = gap_cycles(READ_GAP);
  localparam logic [3:0] SETUP_LAST = 4'(FREEZE_SETUP - 1);
  localparam logic [3:0] WAIT_LAST  = 4'(READ_LAT - 2);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYC - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(FREEZE_HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       tok_m_q, tok_s_q;
  logic       read_q, read_d;
  logic       freeze_q, freeze_d;
  logic       busy_q, busy_d;

  hit_word_t   word_q, word_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;

  logic      rx_start, rx_done;
  hit_word_t rx_word;
  logic      xfer, out_free;

  assign xfer     = valid_q && WordReady;
  assign out_free = !valid_q || WordReady;
  assign rx_start = (state_q == WAIT) && (state_d == SHIFT);

  always_ff @(posedge Clk or negedge RstB) begin
    if (!RstB) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tok_m_q  <= 1'b0;
      tok_s_q  <= 1'b0;
      read_q   <= 1'b0;
      freeze_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tok_m_q  <= TokenIn;
      tok_s_q  <= tok_m_q;
      read_q   <= read_d;
      freeze_q <= freeze_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (Enable && tok_s_q) state_d = SETUP;
      end
      SETUP: begin
        if (cnt_q != SETUP_LAST) begin
          cnt_d = cnt_q + 4'd1;
        end else if (out_free) begin
          state_d = READ;
          cnt_d   = '0;
        end
      end
      READ: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (cnt_q != WAIT_LAST) cnt_d = cnt_q + 4'd1;
        else state_d = SHIFT;
      end
      SHIFT: begin
        if (rx_done) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q != GAP_LAST) begin
          cnt_d = cnt_q + 4'd1;
        end else if (!tok_s_q) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (out_free) begin
          state_d = READ;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q != HOLD_LAST) cnt_d = cnt_q + 4'd1;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_d   = (state_d == READ);
    freeze_d = (state_d != IDLE);
    busy_d   = (state_d != IDLE);
  end

  tjmono_rx_shift u_rx (
    .clk     (Clk),
    .rst_n   (RstB),
    .start_i (rx_start),
    .din_i   (DataIn),
    .done_o  (rx_done),
    .word_o  (rx_word)
  );

  // A freshly captured word wins over the drain of the previous one.
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    count_d = count_q;
    if (xfer && count_q != 16'hFFFF) count_d = count_q + 16'd1;
    if (rx_done) begin
      word_d  = rx_word;
      valid_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge RstB) begin
    if (!RstB) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

`ifdef TJMONO_READOUT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, frame_ts_q, word_ts_q;

  always_ff @(posedge Clk or negedge RstB) begin
    if (!RstB) begin
      ts_q       <= '0;
      frame_ts_q <= '0;
      word_ts_q  <= '0;
    end else begin
      ts_q <= ts_q + 16'd1;
      if (state_q == IDLE && state_d == SETUP) frame_ts_q <= ts_q;
      if (rx_done) word_ts_q <= frame_ts_q;
    end
  end

  assign WordTs = word_ts_q;
`endif

  assign Read      = read_q;
  assign Freeze    = freeze_q;
  assign Busy      = busy_q;
  assign WordData  = word_q;
  assign WordValid = valid_q;
  assign WordCount = count_q;

endmodule

// File: tb/tb_tjmono_readout_ctrl.sv
// Directed/random bench for tjmono_readout_ctrl with a behavioural chip
// model and an in-order word scoreboard.
module tb_tjmono_readout_ctrl;
  import tjmono_readout_pkg::*;

  localparam int RL   = 2;
  localparam int FS   = 4;
  localparam int FH   = 2;
  localparam int GAPC = 2;
  localparam int SPC  = WORD_W + RL + GAPC;

  logic              Clk = 1'b0;
  logic              RstB = 1'b0;
  logic              Enable = 1'b0;
  logic              TokenIn = 1'b0;
  logic              DataIn = 1'b0;
  logic              WordReady = 1'b1;
  logic              Read, Freeze, WordValid, Busy;
  logic [WORD_W-1:0] WordData;
  logic [15:0]       WordCount;
`ifdef TJMONO_READOUT_TIMESTAMP_EN
  logic [15:0]       WordTs;
  logic [15:0]       ts_log[$];
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd = -1000;
  int rises = 0;
  int rise_cyc = 0;
  int fall_cyc = 0;
  logic frz_prev = 1'b0;
  logic [WORD_W-1:0] cur = '0;
  logic [WORD_W-1:0] chip_q[$];
  logic [WORD_W-1:0] exp_q[$];
  int read_log[$];

  tjmono_readout_ctrl dut (
    .Clk       (Clk),
    .RstB      (RstB),
    .Enable    (Enable),
    .TokenIn   (TokenIn),
    .DataIn    (DataIn),
    .Read      (Read),
    .Freeze    (Freeze),
    .WordData  (WordData),
    .WordValid (WordValid),
    .WordReady (WordReady),
    .Busy      (Busy),
`ifdef TJMONO_READOUT_TIMESTAMP_EN
    .WordTs    (WordTs),
`endif
    .WordCount (WordCount)
  );

  always #5 Clk = ~Clk;

  // Chip: holds the token while it has words; bit 26-k appears RL+k
  // cycles after the Read cycle.
  always @(posedge Clk) begin
    int k;
    #1;
    cyc++;
    if (!RstB) begin
      chip_q.delete();
      rd = -1000;
    end else if (Read) begin
      rd = cyc;
      cur = (chip_q.size() > 0) ? chip_q.pop_front() : '0;
    end
    k = cyc - rd - RL;
    DataIn = (k >= 0 && k < WORD_W) ? cur[WORD_W-1-k] : 1'b0;
    TokenIn = (chip_q.size() > 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (RstB) begin
      if (Read) read_log.push_back(cyc);
      if (Freeze && !frz_prev) begin
        rises++;
        rise_cyc = cyc;
      end
      if (!Freeze && frz_prev) fall_cyc = cyc;
      if (WordValid && WordReady) begin
        chk("queue_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("word", WordData, exp_q.pop_front());
`ifdef TJMONO_READOUT_TIMESTAMP_EN
        ts_log.push_back(WordTs);
`endif
      end
    end
    frz_prev = Freeze;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic push_fixed(input logic [WORD_W-1:0] w);
    chip_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic push_word(input logic [5:0] col);
    logic [WORD_W-1:0] w;
    w = {col, 21'($urandom)};
    push_fixed(w);
  endtask

  initial begin
    int base, n, rd2;
    int cols[5] = '{0, 7, 13, 40, 55};
    logic [WORD_W-1:0] w1;

    #3;
    chk("rst_read", Read, 0);
    chk("rst_freeze", Freeze, 0);
    chk("rst_valid", WordValid, 0);
    chk("rst_data", WordData, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_count", WordCount, 0);
    tick(2);
    RstB = 1'b1;
    Enable = 1'b1;
    tick(2);

    // single word
    base = read_log.size();
    push_fixed(27'h5A0F0F3);
    tick(80);
    chk("t1_reads", read_log.size() - base, 1);
    chk("t1_setup", read_log[base] - rise_cyc, FS);
    chk("t1_hold", fall_cyc - read_log[base], RL + WORD_W + GAPC + FH);
    chk("t1_data", WordData, 27'h5A0F0F3);
    chk("t1_count", WordCount, 1);
    chk("t1_pending", exp_q.size(), 0);
    chk("t1_busy", Busy, 0);

    // burst of five
    base = read_log.size();
    foreach (cols[i]) push_word(6'(cols[i]));
    tick(5 * SPC + 60);
    chk("t2_reads", read_log.size() - base, 5);
    for (int i = 1; i < 5; i++)
      chk("t2_spacing", read_log[base+i] - read_log[base+i-1], SPC);
    chk("t2_count", WordCount, 6);
    chk("t2_pending", exp_q.size(), 0);

    // backpressure
    base = read_log.size();
    for (int i = 0; i < 3; i++) push_word(6'($urandom_range(0, 63)));
    n = 0;
    while (!WordValid && n < 200) begin
      tick(1);
      n++;
    end
    chk("t3_first_valid", WordValid, 1);
    tick(1);
    WordReady = 1'b0;
    n = read_log.size();
    tick(100);
    chk("t3_one_read", read_log.size() - n, 1);
    chk("t3_blocked_valid", WordValid, 1);
    chk("t3_blocked_data", WordData, exp_q[0]);
    WordReady = 1'b1;
    tick(100);
    chk("t3_reads", read_log.size() - base, 3);
    chk("t3_pending", exp_q.size(), 0);
    chk("t3_count", WordCount, 9);

    // reset mid-word
    base = read_log.size();
    push_word(6'd3);
    push_word(6'd60);
    n = 0;
    while (read_log.size() < base + 2 && n < 200) begin
      tick(1);
      n++;
    end
    chk("t4_second_read", read_log.size() - base, 2);
    rd2 = read_log[read_log.size()-1];
    n = 0;
    while (cyc < rd2 + RL + 12 && n < 100) begin
      tick(1);
      n++;
    end
    #1 RstB = 1'b0;
    #1;
    chk("t4_read", Read, 0);
    chk("t4_freeze", Freeze, 0);
    chk("t4_valid", WordValid, 0);
    chk("t4_busy", Busy, 0);
    chk("t4_count_clr", WordCount, 0);
    exp_q.delete();
    tick(3);
    RstB = 1'b1;
    tick(2);
    w1 = {6'd21, 21'($urandom)};
    push_fixed(w1);
    tick(80);
    chk("t4_clean_data", WordData, w1);
    chk("t4_count", WordCount, 1);
    chk("t4_pending", exp_q.size(), 0);

    // enable gating
    Enable = 1'b0;
    base = read_log.size();
    n = rises;
    push_word(6'd9);
    tick(50);
    chk("t5_no_read", read_log.size() - base, 0);
    chk("t5_no_freeze", rises - n, 0);
    Enable = 1'b1;
    for (int i = 0; i < 3 && !Freeze; i++) tick(1);
    chk("t5_freeze_rise", Freeze, 1);
    tick(80);
    chk("t5_count", WordCount, 2);
    chk("t5_pending", exp_q.size(), 0);

`ifdef TJMONO_READOUT_TIMESTAMP_EN
    ts_log.delete();
    push_word(6'd1);
    push_word(6'd2);
    tick(1000);
    push_word(6'd3);
    push_word(6'd4);
    tick(150);
    chk("ts_words", ts_log.size(), 4);
    chk("ts_frame_a", ts_log[1], ts_log[0]);
    chk("ts_frame_b", ts_log[3], ts_log[2]);
    chk("ts_delta", 16'(ts_log[2] - ts_log[0]), 16'd1000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
